instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit_pkg.sv | 14 +
 rtl/instruction_fetch_unit_buffer.sv | 55 +++++
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared fetch-stage types and constants
package instruction_fetch_unit_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int PC_STEP     = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_buffer.sv
// rtl/instruction_fetch_unit_buffer.sv - small {pc, instr} FIFO with flush and occupancy count
module fetch_buffer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC/fetch FSM issuing single-outstanding imem requests into a decode FIFO
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_redirect_valid,
    input  logic [XLEN-1:0]        i_redirect_pc,
    output logic                   o_imem_req_valid,
    input  logic                   i_imem_req_ready,
    output logic [XLEN-1:0]        o_imem_addr,
    input  logic                   i_imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
    output logic                   o_instr_valid,
    input  logic                   i_instr_ready,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [XLEN-1:0]        o_instr_pc,
    output logic                   o_fetch_fault
);

    localparam int              CNT_W    = $clog2(BUF_DEPTH + 1);
    localparam int              ENTRY_W  = XLEN + INSTR_WIDTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    fetch_state_e     r_state, w_state_next;
    logic [XLEN-1:0]  r_pc, w_pc_next;
    logic [XLEN-1:0]  r_req_pc, w_req_pc_next;
    logic             r_outstanding, w_outstanding_next;
    logic             w_req_valid, w_req_fire, w_push, w_pop;
    logic [CNT_W-1:0] w_count;
    logic [ENTRY_W-1:0] w_head;

    assign w_req_valid = (r_state == FETCH) && (w_count < FULL_CNT);
    assign w_req_fire  = w_req_valid && i_imem_req_ready;
    assign w_push      = (r_state == WAIT) && i_imem_rsp_valid && !i_redirect_valid;
    assign w_pop       = (w_count != '0) && i_instr_ready;

    // Tracks a request whose response is still owed, even across DROP/HALT
    assign w_outstanding_next = (r_outstanding && !i_imem_rsp_valid) || w_req_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_req_pc      <= w_req_pc_next;
            r_outstanding <= w_outstanding_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_req_pc_next = r_req_pc;
        if (i_redirect_valid) begin
            if (i_redirect_pc[1:0] != 2'b00) begin
                w_state_next = HALT;
            end else begin
                w_pc_next    = i_redirect_pc;
                w_state_next = w_outstanding_next ? DROP : FETCH;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_req_fire) begin
                        w_req_pc_next = r_pc;
                        w_pc_next     = r_pc + XLEN'(PC_STEP);
                        w_state_next  = WAIT;
                    end
                end
                WAIT:    if (i_imem_rsp_valid) w_state_next = FETCH;
                DROP:    if (i_imem_rsp_valid) w_state_next = FETCH;
                default: w_state_next = r_state;
            endcase
        end
    end

    fetch_buffer #(
        .DATA_W (ENTRY_W),
        .DEPTH  (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data ({r_req_pc, i_imem_rsp_data}),
        .i_pop       (w_pop),
        .i_flush     (i_redirect_valid),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // Request valid is held low while reset is asserted
    assign o_imem_req_valid = rst_n && w_req_valid;
    assign o_imem_addr      = r_pc;
    assign o_instr_valid    = (w_count != '0);
    assign o_instr          = w_head[INSTR_WIDTH-1:0];
    assign o_instr_pc       = w_head[ENTRY_W-1:INSTR_WIDTH];
    assign o_fetch_fault    = (r_state == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - table, directed and randomized checks of instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready = 1'b0;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_data = '0;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        o_fetch_fault;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_instr_valid    (o_instr_valid),
        .i_instr_ready    (i_instr_ready),
        .o_instr          (o_instr),
        .o_instr_pc       (o_instr_pc),
        .o_fetch_fault    (o_fetch_fault)
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rq_rdy, input logic rsp_v, input logic [31:0] rsp_d,
                         input logic ins_rdy, input logic redir, input logic [31:0] tgt);
        @(negedge clk);
        i_imem_req_ready = rq_rdy;
        i_imem_rsp_valid = rsp_v;
        i_imem_rsp_data  = rsp_d;
        i_instr_ready    = ins_rdy;
        i_redirect_valid = redir;
        i_redirect_pc    = tgt;
    endtask

    task automatic expect_out(input string tag, input logic rv, input logic [31:0] addr,
                              input logic iv, input logic [31:0] ipc);
        chk({tag, ".req_valid"},   32'(o_imem_req_valid), 32'(rv));
        chk({tag, ".addr"},        o_imem_addr, addr);
        chk({tag, ".instr_valid"}, 32'(o_instr_valid), 32'(iv));
        if (iv) begin
            chk({tag, ".instr_pc"}, o_instr_pc, ipc);
            chk({tag, ".instr"},    o_instr, memw(ipc));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_imem_req_ready = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_instr_ready    = 1'b0;
        i_redirect_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rq_rdy;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        ins_rdy;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[10];

    logic [31:0] exp_req, exp_out, mem_addr, tgt;
    logic        halted, mem_pend, was_pend, redir_last, redir, rsp_v;
    int          mem_cnt, n_pops;

    initial begin
        // 1-cycle memory, decode always ready: even rows request, odd rows respond
        for (int j = 0; j < 5; j++) begin
            tbl[2*j]   = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'(4*j), (j > 0), 32'(4*j - 4)};
            tbl[2*j+1] = '{1'b1, 1'b1, memw(32'(4*j)), 1'b1, 1'b0, 32'(4*j + 4), 1'b0, 32'h0};
        end

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.req_valid",   32'(o_imem_req_valid), 32'h0);
        chk("rst.addr",        o_imem_addr, 32'h0);
        chk("rst.instr_valid", 32'(o_instr_valid), 32'h0);
        chk("rst.instr",       o_instr, 32'h0);
        chk("rst.instr_pc",    o_instr_pc, 32'h0);
        chk("rst.fault",       32'(o_fetch_fault), 32'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].rq_rdy, tbl[k].rsp_v, tbl[k].rsp_d, tbl[k].ins_rdy, 1'b0, 32'h0);
            expect_out($sformatf("tbl%0d", k), tbl[k].exp_rv, tbl[k].exp_addr, tbl[k].exp_iv, tbl[k].exp_pc);
        end

        // Backpressure: FIFO fills, fetch stops, drains in order, resumes at 0x8
        do_reset();
        drive(1, 0, 0, 0, 0, 0);          expect_out("a0", 1, 32'h0, 0, 0);
        drive(0, 1, memw(32'h0), 0, 0, 0); expect_out("a1", 0, 32'h4, 0, 0);
        drive(1, 0, 0, 0, 0, 0);          expect_out("a2", 1, 32'h4, 1, 32'h0);
        drive(0, 1, memw(32'h4), 0, 0, 0); expect_out("a3", 0, 32'h8, 1, 32'h0);
        drive(1, 0, 0, 0, 0, 0);          expect_out("a4", 0, 32'h8, 1, 32'h0);
        drive(0, 0, 0, 1, 0, 0);          expect_out("a5", 0, 32'h8, 1, 32'h0);
        drive(0, 0, 0, 1, 0, 0);          expect_out("a6", 1, 32'h8, 1, 32'h4);
        drive(1, 0, 0, 0, 0, 0);          expect_out("a7", 1, 32'h8, 0, 0);

        // Redirect while waiting on 0x8: stale word dropped
        drive(0, 0, 0, 0, 1, 32'h100);         expect_out("b0", 0, 32'hC, 0, 0);
        drive(1, 1, memw(32'h8), 1, 0, 0);     expect_out("b1", 0, 32'h100, 0, 0);
        drive(1, 0, 0, 1, 0, 0);               expect_out("b2", 1, 32'h100, 0, 0);
        drive(0, 1, memw(32'h100), 1, 0, 0);   expect_out("b3", 0, 32'h104, 0, 0);
        drive(1, 0, 0, 1, 0, 0);               expect_out("b4", 1, 32'h104, 1, 32'h100);

        // Redirect coinciding with response and pop
        drive(0, 1, memw(32'h104), 0, 0, 0);   expect_out("c0", 0, 32'h108, 0, 0);
        drive(1, 0, 0, 0, 0, 0);               expect_out("c1", 1, 32'h108, 1, 32'h104);
        drive(0, 1, memw(32'h108), 1, 1, 32'h300); expect_out("c2", 0, 32'h10C, 1, 32'h104);
        drive(1, 0, 0, 1, 0, 0);               expect_out("c3", 1, 32'h300, 0, 0);
        drive(0, 1, memw(32'h300), 1, 0, 0);   expect_out("c4", 0, 32'h304, 0, 0);
        drive(0, 0, 0, 1, 0, 0);               expect_out("c5", 1, 32'h304, 1, 32'h300);

        // Misaligned redirect halts, aligned redirect resumes
        drive(0, 0, 0, 0, 1, 32'h102);         expect_out("d0", 1, 32'h304, 0, 0);
        drive(1, 1, 32'hDEAD_BEEF, 1, 0, 0);   expect_out("d1", 0, 32'h304, 0, 0);
        chk("d1.fault", 32'(o_fetch_fault), 32'h1);
        drive(1, 0, 0, 1, 1, 32'h200);         expect_out("d2", 0, 32'h304, 0, 0);
        chk("d2.fault", 32'(o_fetch_fault), 32'h1);
        drive(0, 0, 0, 1, 1, 32'hFFFF_FFFC);   expect_out("d3", 1, 32'h200, 0, 0);
        chk("d3.fault", 32'(o_fetch_fault), 32'h0);

        // PC wrap, then asynchronous reset while waiting
        drive(1, 0, 0, 0, 0, 0);                  expect_out("e0", 1, 32'hFFFF_FFFC, 0, 0);
        drive(0, 1, memw(32'hFFFF_FFFC), 0, 0, 0); expect_out("e1", 0, 32'h0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);                  expect_out("e2", 1, 32'h0, 1, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 0);                  expect_out("e3", 0, 32'h4, 1, 32'hFFFF_FFFC);
        #2 rst_n = 1'b0;
        #1;
        chk("e.rst.req_valid",   32'(o_imem_req_valid), 32'h0);
        chk("e.rst.addr",        o_imem_addr, 32'h0);
        chk("e.rst.instr_valid", 32'(o_instr_valid), 32'h0);
        chk("e.rst.fault",       32'(o_fetch_fault), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0);                  expect_out("e4", 1, 32'h0, 0, 0);

        // Randomized run against a stream-level reference model
        do_reset();
        exp_req = '0; exp_out = '0; halted = 1'b0; mem_pend = 1'b0;
        redir_last = 1'b0; mem_cnt = 0; n_pops = 0; mem_addr = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            chk("rnd.fault", 32'(o_fetch_fault), 32'(halted));
            if (halted || redir_last) chk("rnd.flushed", 32'(o_instr_valid), 32'h0);
            if (halted) chk("rnd.req_halted", 32'(o_imem_req_valid), 32'h0);
            if (o_instr_valid) begin
                chk("rnd.instr_pc", o_instr_pc, exp_out);
                chk("rnd.instr",    o_instr, memw(exp_out));
            end

            was_pend = mem_pend;
            rsp_v = mem_pend && (mem_cnt == 0);
            if (mem_pend && mem_cnt != 0) mem_cnt--;
            i_imem_rsp_valid = rsp_v;
            i_imem_rsp_data  = rsp_v ? memw(mem_addr) : $urandom;
            i_imem_req_ready = ($urandom_range(0, 3) != 0);
            i_instr_ready    = ($urandom_range(0, 2) != 0);
            redir = ($urandom_range(0, 19) == 0);
            tgt   = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            i_redirect_valid = redir;
            i_redirect_pc    = tgt;

            if (rsp_v) mem_pend = 1'b0;
            if (o_imem_req_valid && i_imem_req_ready) begin
                chk("rnd.one_outstanding", 32'(was_pend), 32'h0);
                chk("rnd.req_addr", o_imem_addr, exp_req);
                mem_addr = exp_req;
                mem_pend = 1'b1;
                mem_cnt  = $urandom_range(0, 2);
                exp_req  = exp_req + 32'd4;
            end
            if (o_instr_valid && i_instr_ready) begin
                exp_out = exp_out + 32'd4;
                n_pops++;
            end
            if (redir) begin
                if (tgt[1:0] == 2'b00) begin
                    exp_req = tgt;
                    exp_out = tgt;
                    halted  = 1'b0;
                end else begin
                    halted = 1'b1;
                end
            end
            redir_last = redir;
        end
        chk("rnd.progress", 32'(n_pops >= 200), 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
